// File: rtl/button_reader_if.sv
// rtl/button_reader_if.sv - button pin and conditioned outputs of one button_reader
interface button_reader_if;
  logic       in_btn_n;
  logic       out_pressed;
  logic       out_press_pulse;
  logic       out_release_pulse;
  logic       out_long_pulse;
  logic [5:0] out_press_count;

  modport master (
    output in_btn_n,
    input  out_pressed,
    input  out_press_pulse,
    input  out_release_pulse,
    input  out_long_pulse,
    input  out_press_count
  );

  modport slave (
    input  in_btn_n,
    output out_pressed,
    output out_press_pulse,
    output out_release_pulse,
    output out_long_pulse,
    output out_press_count
  );
endinterface

// File: rtl/button_reader.sv
// rtl/button_reader.sv - synchronise and debounce an active-low push button
module button_reader #(
  parameter int DEBOUNCE_CYCLES   = 1048576,
  parameter int LONG_PRESS_CYCLES = 16777216
) (
  input  logic           in_clk,
  input  logic           in_rst,
  button_reader_if.slave btn
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = (LONG_PRESS_CYCLES > 0) ? $clog2(LONG_PRESS_CYCLES + 1) : 1;
  // dcnt holds (samples seen - 1) on the cycle that completes the debounce window
  localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_PRESS_CYCLES);

  typedef enum logic [1:0] {RELEASED, PRESS_DB, PRESSED, RELEASE_DB} state_t;

  state_t        state, state_next;
  logic          s1, s2;
  logic          raw;
  logic [DW-1:0] dcnt, dcnt_next;
  logic [HW-1:0] hcnt, hcnt_next;
  logic          press_act, release_act, long_fire;
  logic          pressed_q, press_pulse_q, release_pulse_q, long_pulse_q;
  logic [5:0]    count_q;

  assign raw = s2;

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      s1              <= 1'b0;
      s2              <= 1'b0;
      state           <= RELEASED;
      dcnt            <= '0;
      hcnt            <= '0;
      pressed_q       <= 1'b0;
      press_pulse_q   <= 1'b0;
      release_pulse_q <= 1'b0;
      long_pulse_q    <= 1'b0;
      count_q         <= '0;
    end else begin
      s1              <= ~btn.in_btn_n;
      s2              <= s1;
      state           <= state_next;
      dcnt            <= dcnt_next;
      hcnt            <= hcnt_next;
      press_pulse_q   <= press_act;
      release_pulse_q <= release_act;
      long_pulse_q    <= long_fire;
      if (press_act) begin
        pressed_q <= 1'b1;
        count_q   <= count_q + 6'd1;
      end else if (release_act) begin
        pressed_q <= 1'b0;
      end
    end
  end

  always_comb begin
    state_next  = state;
    dcnt_next   = dcnt;
    press_act   = 1'b0;
    release_act = 1'b0;
    case (state)
      RELEASED: begin
        if (raw) begin
          if (DB_LAST == '0) begin
            press_act = 1'b1;
          end else begin
            state_next = PRESS_DB;
            dcnt_next  = DW'(1);
          end
        end
      end
      PRESS_DB: begin
        if (!raw) begin
          state_next = RELEASED;
          dcnt_next  = '0;
        end else if (dcnt == DB_LAST) begin
          press_act = 1'b1;
        end else begin
          dcnt_next = dcnt + DW'(1);
        end
      end
      PRESSED: begin
        if (!raw) begin
          if (DB_LAST == '0) begin
            release_act = 1'b1;
          end else begin
            state_next = RELEASE_DB;
            dcnt_next  = DW'(1);
          end
        end
      end
      RELEASE_DB: begin
        if (raw) begin
          state_next = PRESSED;
          dcnt_next  = '0;
        end else if (dcnt == DB_LAST) begin
          release_act = 1'b1;
        end else begin
          dcnt_next = dcnt + DW'(1);
        end
      end
      default: begin
        state_next = RELEASED;
        dcnt_next  = '0;
      end
    endcase
    if (press_act) begin
      state_next = PRESSED;
      dcnt_next  = '0;
    end else if (release_act) begin
      state_next = RELEASED;
      dcnt_next  = '0;
    end
  end

  // Hold timing spans PRESSED and RELEASE_DB; saturation gives one long pulse per press
  always_comb begin
    hcnt_next = hcnt;
    long_fire = 1'b0;
    if (press_act) begin
      hcnt_next = '0;
    end else if ((state == PRESSED || state == RELEASE_DB) && hcnt != HOLD_MAX) begin
      hcnt_next = hcnt + HW'(1);
      long_fire = (hcnt + HW'(1) == HOLD_MAX);
    end
  end

  assign btn.out_pressed       = pressed_q;
  assign btn.out_press_pulse   = press_pulse_q;
  assign btn.out_release_pulse = release_pulse_q;
  assign btn.out_long_pulse    = long_pulse_q;
  assign btn.out_press_count   = count_q;

endmodule
